// File: rtl/pc_branch_if.sv
// pc_branch_if: bundle between the EX stage (master) and pc_branch_unit (slave).
// EX drives the branch operands and condition bits. The unit returns the program
// counter, its pipeline copies, the squash control and the branch statistics.
interface pc_branch_if #(
    parameter int CNT_W = 16
);
    logic [31:0]      BrA;
    logic [31:0]      RAA;
    logic             BS_one;
    logic             BS_zero;
    logic             PS_out;
    logic             Z;
    logic [31:0]      PC;
    logic [31:0]      PC_1;
    logic [31:0]      PC_D;
    logic [31:0]      PC_M2;
    logic             FLUSH;
    logic             BR_TAKEN;
    logic [CNT_W-1:0] BR_COUNT;

    // EX side: produces the branch operands and consumes the PC copies.
    modport master (
        output BrA, RAA, BS_one, BS_zero, PS_out, Z,
        input  PC, PC_1, PC_D, PC_M2, FLUSH, BR_TAKEN, BR_COUNT
    );

    // Branch unit side: resolves the branch and owns the PC.
    modport slave (
        input  BrA, RAA, BS_one, BS_zero, PS_out, Z,
        output PC, PC_1, PC_D, PC_M2, FLUSH, BR_TAKEN, BR_COUNT
    );
endinterface

// File: rtl/pc_branch_unit.sv
// pc_branch_unit: resolves the EX-stage branch and owns the program counter.
// A taken branch redirects the PC on the next cycle. The next FLUSH_CYCLES
// non-stalled cycles then squash the wrong-path IF/DOF contents.
// Optional feature macro PC_DELAY_SLOT_EN selects architected delay slots.
// In that build FLUSH is never raised and the branch select is decoded on every
// non-stalled cycle.
module pc_branch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          FLUSH_CYCLES = 2,
    parameter int          CNT_W        = 16
) (
    input  logic CLOCK,
    input  logic RESET,
    input  logic STALL,
    pc_branch_if.slave br
);

`ifdef PC_DELAY_SLOT_EN
    localparam bit SQUASH_EN = 1'b0;
`else
    localparam bit SQUASH_EN = 1'b1;
`endif

    typedef enum logic {ST_RUN, ST_FLUSH} state_t;

    state_t           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      pcd_q, pcd_d;
    logic [31:0]      pcm2_q, pcm2_d;
    logic             flush_q, flush_d;
    logic             taken_q, taken_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [31:0]      pc_inc;
    logic             take;
    logic [31:0]      target;

    assign pc_inc = pc_q + 32'd1;

    // Decode the branch select into a take decision and a target address.
    always_comb begin
        // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
        take   = 1'b0;
        target = br.BrA;
        unique case ({br.BS_one, br.BS_zero})
            2'b01:   take = br.Z ^ br.PS_out;
            2'b10: begin
                take   = 1'b1;
                target = br.RAA;
            end
            2'b11:   take = 1'b1;
            default: take = 1'b0;
        endcase
    end

    // Next-state logic for the PC pipeline, the squash FSM and the branch counter.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pcd_d   = pcd_q;
        pcm2_d  = pcm2_q;
        flush_d = flush_q;
        cnt_d   = cnt_q;
        count_d = count_q;
        taken_d = 1'b0;
        if (!STALL) begin
            pc_d   = pc_inc;
            pcd_d  = pc_inc;
            pcm2_d = pcd_q;
            if (state_q == ST_RUN) begin
                if (take) begin
                    pc_d    = target;
                    taken_d = 1'b1;
                    if (count_q != {CNT_W{1'b1}}) begin
                        count_d = count_q + 1'b1;
                    end
                    if (SQUASH_EN) begin
                        cnt_d   = 2'(FLUSH_CYCLES);
                        flush_d = 1'b1;
                        state_d = ST_FLUSH;
                    end
                end
            end else begin
                // The wrong path is being squashed, so the branch select is ignored here.
                cnt_d = cnt_q - 2'd1;
                if (cnt_q == 2'd1) begin
                    flush_d = 1'b0;
                    state_d = ST_RUN;
                end
            end
        end
    end

    // State register with a synchronous active-low reset. Reset takes priority over STALL.
    always_ff @(posedge CLOCK) begin
        // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
        if (!RESET) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_VECTOR;
            pcd_q   <= 32'd0;
            pcm2_q  <= 32'd0;
            flush_q <= 1'b0;
            taken_q <= 1'b0;
            count_q <= '0;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pcd_q   <= pcd_d;
            pcm2_q  <= pcm2_d;
            flush_q <= flush_d;
            taken_q <= taken_d;
            count_q <= count_d;
            cnt_q   <= cnt_d;
        end
    end

    assign br.PC       = pc_q;
    assign br.PC_1     = pc_inc;
    assign br.PC_D     = pcd_q;
    assign br.PC_M2    = pcm2_q;
    assign br.FLUSH    = flush_q;
    assign br.BR_TAKEN = taken_q;
    assign br.BR_COUNT = count_q;

endmodule

// File: tb/tb_pc_branch_unit.sv
// tb_pc_branch_unit: directed, table-driven bench for pc_branch_unit.
// The main instance uses RESET_VECTOR=0x10, FLUSH_CYCLES=2 and CNT_W=16.
// The second instance uses FLUSH_CYCLES=1 and CNT_W=2 to reach counter saturation.
module tb_pc_branch_unit;

`ifdef PC_DELAY_SLOT_EN
    localparam bit DS = 1'b1;
`else
    localparam bit DS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic stall = 1'b0;
    logic stall2 = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    pc_branch_if #(.CNT_W(16)) if1 ();
    pc_branch_if #(.CNT_W(2))  if2 ();

    pc_branch_unit #(.RESET_VECTOR(32'h10), .FLUSH_CYCLES(2), .CNT_W(16)) dut (
        .CLOCK(clk), .RESET(rst_n), .STALL(stall), .br(if1)
    );

    pc_branch_unit #(.RESET_VECTOR(32'h10), .FLUSH_CYCLES(1), .CNT_W(2)) dut2 (
        .CLOCK(clk), .RESET(rst_n), .STALL(stall2), .br(if2)
    );

    typedef struct {
        logic        stall;
        logic [1:0]  bs;
        logic        ps;
        logic        z;
        logic [31:0] bra;
        logic [31:0] raa;
        logic [31:0] pc;
        logic [31:0] pcd;
        logic [31:0] pcm2;
        logic        flush;
        logic        taken;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance one rising edge, then move 1 time unit away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic [1:0] bs, input logic ps, input logic z,
                         input logic [31:0] bra, input logic [31:0] raa);
        stall      = s;
        if1.BS_one = bs[1];
        if1.BS_zero = bs[0];
        if1.PS_out = ps;
        if1.Z      = z;
        if1.BrA    = bra;
        if1.RAA    = raa;
    endtask

    // Watchdog: the bench must always terminate on its own.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int takes;
        drive(1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0);
        if2.BS_one = 1'b0; if2.BS_zero = 1'b0; if2.PS_out = 1'b0; if2.Z = 1'b0;
        if2.BrA = 32'h200; if2.RAA = 32'h0;

        // Reset state.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("rst_pc", if1.PC, 32'h10);
        check("rst_pc1", if1.PC_1, 32'h11);
        check("rst_pcd", if1.PC_D, 32'h0);
        check("rst_pcm2", if1.PC_M2, 32'h0);
        check("rst_flush", 32'(if1.FLUSH), 32'h0);
        check("rst_taken", 32'(if1.BR_TAKEN), 32'h0);
        check("rst_count", 32'(if1.BR_COUNT), 32'h0);

`ifndef PC_DELAY_SLOT_EN
        // Each row lists stall, bs, ps, z, bra, raa, then pc, pcd, pcm2, flush, taken and count after the edge.
        vecs.push_back(vec_t'{0, 2'b00, 0, 0, 32'h0,  32'h0,  32'h11, 32'h11, 32'h00, 0, 0, 16'd0});
        vecs.push_back(vec_t'{0, 2'b00, 0, 0, 32'h0,  32'h0,  32'h12, 32'h12, 32'h11, 0, 0, 16'd0});
        vecs.push_back(vec_t'{0, 2'b00, 0, 0, 32'h0,  32'h0,  32'h13, 32'h13, 32'h12, 0, 0, 16'd0});
        vecs.push_back(vec_t'{0, 2'b00, 0, 0, 32'h0,  32'h0,  32'h14, 32'h14, 32'h13, 0, 0, 16'd0});
        vecs.push_back(vec_t'{0, 2'b01, 0, 1, 32'h40, 32'h0,  32'h40, 32'h15, 32'h14, 1, 1, 16'd1});
        vecs.push_back(vec_t'{0, 2'b01, 0, 1, 32'h40, 32'h0,  32'h41, 32'h41, 32'h15, 1, 0, 16'd1});
        vecs.push_back(vec_t'{0, 2'b00, 0, 0, 32'h0,  32'h0,  32'h42, 32'h42, 32'h41, 0, 0, 16'd1});
        vecs.push_back(vec_t'{0, 2'b01, 0, 0, 32'h40, 32'h0,  32'h43, 32'h43, 32'h42, 0, 0, 16'd1});
        vecs.push_back(vec_t'{0, 2'b01, 1, 0, 32'h50, 32'h0,  32'h50, 32'h44, 32'h43, 1, 1, 16'd2});
        vecs.push_back(vec_t'{0, 2'b00, 0, 0, 32'h0,  32'h0,  32'h51, 32'h51, 32'h44, 1, 0, 16'd2});
        vecs.push_back(vec_t'{0, 2'b00, 0, 0, 32'h0,  32'h0,  32'h52, 32'h52, 32'h51, 0, 0, 16'd2});
        vecs.push_back(vec_t'{0, 2'b10, 0, 0, 32'h33, 32'h80, 32'h80, 32'h53, 32'h52, 1, 1, 16'd3});
        vecs.push_back(vec_t'{0, 2'b11, 0, 0, 32'h99, 32'h0,  32'h81, 32'h81, 32'h53, 1, 0, 16'd3});
        vecs.push_back(vec_t'{0, 2'b11, 0, 0, 32'h99, 32'h0,  32'h82, 32'h82, 32'h81, 0, 0, 16'd3});
        vecs.push_back(vec_t'{0, 2'b11, 0, 0, 32'h99, 32'h0,  32'h99, 32'h83, 32'h82, 1, 1, 16'd4});
        vecs.push_back(vec_t'{0, 2'b00, 0, 0, 32'h0,  32'h0,  32'h9a, 32'h9a, 32'h83, 1, 0, 16'd4});
        vecs.push_back(vec_t'{1, 2'b00, 0, 0, 32'h0,  32'h0,  32'h9a, 32'h9a, 32'h83, 1, 0, 16'd4});
        vecs.push_back(vec_t'{1, 2'b11, 0, 0, 32'h77, 32'h0,  32'h9a, 32'h9a, 32'h83, 1, 0, 16'd4});
        vecs.push_back(vec_t'{0, 2'b00, 0, 0, 32'h0,  32'h0,  32'h9b, 32'h9b, 32'h9a, 0, 0, 16'd4});
        vecs.push_back(vec_t'{1, 2'b01, 0, 1, 32'h60, 32'h0,  32'h9b, 32'h9b, 32'h9a, 0, 0, 16'd4});
        vecs.push_back(vec_t'{0, 2'b01, 0, 1, 32'h60, 32'h0,  32'h60, 32'h9c, 32'h9b, 1, 1, 16'd5});
        vecs.push_back(vec_t'{0, 2'b00, 0, 0, 32'h0,  32'h0,  32'h61, 32'h61, 32'h9c, 1, 0, 16'd5});
        vecs.push_back(vec_t'{0, 2'b00, 0, 0, 32'h0,  32'h0,  32'h62, 32'h62, 32'h61, 0, 0, 16'd5});

        foreach (vecs[i]) begin
            drive(vecs[i].stall, vecs[i].bs, vecs[i].ps, vecs[i].z, vecs[i].bra, vecs[i].raa);
            step();
            check($sformatf("v%0d_pc", i), if1.PC, vecs[i].pc);
            check($sformatf("v%0d_pc1", i), if1.PC_1, vecs[i].pc + 32'd1);
            check($sformatf("v%0d_pcd", i), if1.PC_D, vecs[i].pcd);
            check($sformatf("v%0d_pcm2", i), if1.PC_M2, vecs[i].pcm2);
            check($sformatf("v%0d_flush", i), 32'(if1.FLUSH), 32'(vecs[i].flush));
            check($sformatf("v%0d_taken", i), 32'(if1.BR_TAKEN), 32'(vecs[i].taken));
            check($sformatf("v%0d_count", i), 32'(if1.BR_COUNT), 32'(vecs[i].cnt));
        end

        // Wrap: jump to 0xFFFFFFFD, let the flush run out, then stall at 0xFFFFFFFF.
        drive(1'b0, 2'b10, 1'b0, 1'b0, 32'h0, 32'hFFFF_FFFD);
        step();
        check("wrap_jump_pc", if1.PC, 32'hFFFF_FFFD);
        drive(1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        step();
        check("wrap_pre_pc", if1.PC, 32'hFFFF_FFFF);
        check("wrap_pre_flush", 32'(if1.FLUSH), 32'h0);
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("wrap_stall%0d_pc", k), if1.PC, 32'hFFFF_FFFF);
            check($sformatf("wrap_stall%0d_pc1", k), if1.PC_1, 32'h0);
        end
        stall = 1'b0;
        step();
        check("wrap_pc", if1.PC, 32'h0);
        check("wrap_pc1", if1.PC_1, 32'h1);

        // Reset during FLUSH with STALL high: reset wins and the pending flush is discarded.
        drive(1'b0, 2'b11, 1'b0, 1'b0, 32'h500, 32'h0);
        step();
        check("rmf_take_pc", if1.PC, 32'h500);
        check("rmf_take_flush", 32'(if1.FLUSH), 32'h1);
        drive(1'b1, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0);
        rst_n = 1'b0;
        step();
        check("rmf_pc", if1.PC, 32'h10);
        check("rmf_pcd", if1.PC_D, 32'h0);
        check("rmf_flush", 32'(if1.FLUSH), 32'h0);
        check("rmf_count", 32'(if1.BR_COUNT), 32'h0);
        rst_n = 1'b1;
        stall = 1'b0;
        step();
        check("rmf_after_pc", if1.PC, 32'h11);
        check("rmf_after_flush", 32'(if1.FLUSH), 32'h0);
`else
        // Delay-slot build: branches redirect the PC without a flush and are decoded every cycle.
        drive(1'b0, 2'b11, 1'b0, 1'b0, 32'h20, 32'h0);
        step();
        check("ds_pc0", if1.PC, 32'h20);
        check("ds_flush0", 32'(if1.FLUSH), 32'h0);
        check("ds_taken0", 32'(if1.BR_TAKEN), 32'h1);
        check("ds_count0", 32'(if1.BR_COUNT), 32'h1);
        drive(1'b0, 2'b11, 1'b0, 1'b0, 32'h30, 32'h0);
        step();
        check("ds_pc1", if1.PC, 32'h30);
        check("ds_flush1", 32'(if1.FLUSH), 32'h0);
        check("ds_count1", 32'(if1.BR_COUNT), 32'h2);
        drive(1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        check("ds_pc2", if1.PC, 32'h31);
        check("ds_flush2", 32'(if1.FLUSH), 32'h0);
        check("ds_taken2", 32'(if1.BR_TAKEN), 32'h0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
`endif

        // Second instance: a branch is held on every cycle with FLUSH_CYCLES=1 and a 2-bit counter.
        // Squash mode takes on every other edge, while delay-slot mode takes on every edge.
        if2.BS_one = 1'b1;
        if2.BS_zero = 1'b1;
        takes = 0;
        for (int e = 1; e <= 8; e++) begin
            bit tk;
            tk = DS || (e % 2 == 1);
            if (tk) takes++;
            step();
            check($sformatf("sat_e%0d_pc", e), if2.PC, tk ? 32'h200 : 32'h201);
            check($sformatf("sat_e%0d_flush", e), 32'(if2.FLUSH), 32'(tk && !DS));
            check($sformatf("sat_e%0d_count", e), 32'(if2.BR_COUNT), (takes > 3) ? 32'd3 : 32'(takes));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
